// File: rtl/ctrl_pipe_stage.sv
// Pipeline stage register with ready/valid handshake, optional 2-entry skid buffer,
// synchronous flush and a kill counter that drops the next N accepted entries.
module ctrl_pipe_stage #(
  parameter int unsigned       WIDTH  = 16,
  parameter logic [WIDTH-1:0]  BUBBLE = '0,
  parameter bit                SKID   = 1'b1,
  parameter int unsigned       KILL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              flush,
  input  logic              kill_req,
  input  logic [KILL_W-1:0] kill_cnt,
  output logic              kill_pending,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [WIDTH-1:0]  main_d_q, main_d_d;
  logic [WIDTH-1:0]  skid_d_q, skid_d_d;
  logic [KILL_W-1:0] kill_q, kill_d;

  logic in_xfer, out_xfer, kill_now, keep;

  // With the skid buffer, in_ready comes straight from a flop so out_ready never reaches it.
  assign in_ready = SKID ? !skid_v_q : (!main_v_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_v_q && out_ready;
  assign kill_now = (kill_q != '0);
  assign keep     = in_xfer && !kill_now && !flush;

  always_comb begin
    kill_d = kill_q;
    if (flush) begin
      kill_d = '0;
    end else if (kill_req) begin
      kill_d = kill_cnt;
    end else if (in_xfer && kill_now) begin
      kill_d = kill_q - KILL_W'(1);
    end
  end

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d_d = BUBBLE;
    end else if (SKID) begin
      if (!main_v_q) begin
        if (keep) begin
          main_v_d = 1'b1;
          main_d_d = in_data;
        end
      end else if (out_xfer) begin
        if (skid_v_q) begin
          // Skid entry is older than anything upstream; in_ready is low here.
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end else begin
          main_v_d = keep;
          if (keep) main_d_d = in_data;
        end
      end else if (keep) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data;
      end
    end else begin
      if (!main_v_q || out_xfer) begin
        main_v_d = keep;
        if (keep) main_d_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= BUBBLE;
      skid_d_q <= BUBBLE;
      kill_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      kill_q   <= kill_d;
    end
  end

  assign out_valid    = main_v_q;
  assign out_data     = main_v_q ? main_d_q : BUBBLE;
  assign kill_pending = kill_now;
  assign occupancy    = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: a SKID=1 and a SKID=0 instance share one stimulus stream;
// each has a queue-based reference model and a monitor that checks every output cycle.
module tb_ctrl_pipe_stage;

  localparam logic [15:0] Bubble = 16'h0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        kill_req;
  logic [1:0]  kill_cnt;

  logic [1:0]  in_ready_w;
  logic [1:0]  out_valid_w;
  logic [1:0]  kill_pend_w;
  logic [15:0] out_data_w [2];
  logic [1:0]  occ_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, idx, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_pipe_stage #(
      .WIDTH (16),
      .BUBBLE(Bubble),
      .SKID  (g == 0),
      .KILL_W(2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready_w[g]),
      .in_data     (in_data),
      .out_valid   (out_valid_w[g]),
      .out_ready   (out_ready),
      .out_data    (out_data_w[g]),
      .flush       (flush),
      .kill_req    (kill_req),
      .kill_cnt    (kill_cnt),
      .kill_pending(kill_pend_w[g]),
      .occupancy   (occ_w[g])
    );

    logic [15:0] exp_q[$];
    int unsigned kill_m = 0;

    // Monitor: state checks, then compare/pop on every output transfer.
    always @(negedge clk) begin
      int sz;
      if (!rst) begin
        sz = exp_q.size();
        chk("out_valid", g, out_valid_w[g], sz > 0);
        chk("occupancy", g, occ_w[g], sz);
        chk("kill_pending", g, kill_pend_w[g], kill_m != 0);
        chk("in_ready", g, in_ready_w[g], (g == 0) ? (sz < 2) : (sz == 0 || out_ready));
        if (sz == 0) begin
          chk("bubble", g, out_data_w[g], Bubble);
        end else begin
          chk("out_data", g, out_data_w[g], exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end

    // Reference model: entries are a FIFO; kill/flush rules applied per accepted input.
    always @(negedge clk) begin
      #1;
      if (rst || flush) begin
        exp_q.delete();
        kill_m = 0;
      end else begin
        if (in_valid && in_ready_w[g]) begin
          if (kill_m > 0) kill_m--;
          else exp_q.push_back(in_data);
        end
        if (kill_req) kill_m = kill_cnt;
      end
    end
  end

  task automatic drive(input bit iv, input logic [15:0] d, input bit ordy, input bit fl,
                       input bit kr, input logic [1:0] kc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    kill_req  = kr;
    kill_cnt  = kc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 0; flush = 0; kill_req = 0; kill_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Stream A,B,C with a stall from B onward, then release
    drive(1, 16'h00a0, 1, 0, 0, 0);
    drive(1, 16'h00b0, 0, 0, 0, 0);
    drive(1, 16'h00c0, 0, 0, 0, 0);
    drive(1, 16'h00c0, 0, 0, 0, 0);
    drive(1, 16'h00c0, 1, 0, 0, 0);
    drive(1, 16'h00c0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0, 0);

    // Kill 2 with X transferring in the same cycle
    drive(1, 16'h0111, 1, 0, 1, 2);
    drive(1, 16'h0222, 1, 0, 0, 0);
    drive(1, 16'h0333, 1, 0, 0, 0);
    drive(1, 16'h0444, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);

    // Kill reload while counter is 1
    drive(1, 16'h0501, 1, 0, 1, 1);
    drive(1, 16'h0502, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) drive(1, 16'h0510 + 16'(i), 1, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);

    // Flush beats kill_req and drops the concurrent input
    drive(1, 16'h0601, 0, 0, 0, 0);
    drive(1, 16'h0602, 0, 0, 0, 0);
    drive(1, 16'h0603, 0, 1, 1, 2);
    drive(1, 16'h0604, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 1, 0, 0, 0);

    // Toggling out_ready under continuous input
    for (int i = 0; i < 6; i++) drive(1, 16'h0700 + 16'(i), (i % 2) == 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with entries held
    drive(1, 16'h0801, 0, 0, 0, 0);
    drive(1, 16'h0802, 0, 0, 0, 0);
    in_valid = 0; out_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, out_valid_w[i], 0);
      chk("rst_out_data", i, out_data_w[i], Bubble);
      chk("rst_occupancy", i, occ_w[i], 0);
      chk("rst_in_ready", i, in_ready_w[i], 1);
      chk("rst_kill_pending", i, kill_pend_w[i], 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, 2'($urandom_range(0, 3)));
    end
    repeat (5) drive(0, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Parametrised control/data pipeline stage register for the RISC-V core. It generalises the fixed X→M control register into a WIDTH-bit payload stage with ready/valid handshake, an optional 2-entry skid buffer, and a programmable bubble value. It also supports synchronous flush and an N-deep kill counter that discards the next N accepted entries after a taken branch or jump. Instances sit between any two pipeline stages (D→X, X→M, M→W), and a stall propagates upstream through `in_ready`.

## Interface
- `WIDTH`, 16, payload width in bits (≥1).
- `BUBBLE`, 0, `WIDTH`-bit payload driven whenever the stage holds no valid entry, and loaded on reset.
- `SKID`, 1: 1 selects a 2-entry skid buffer with a registered `in_ready`; 0 selects a single entry with a combinational `in_ready`.
- `KILL_W`, 2, width of the kill counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  downstream entry present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  downstream payload; equals `BUBBLE` when `out_valid`=0.
- `flush`  in  1  synchronous clear of all contents and of the kill counter.
- `kill_req`  in  1  load the kill counter from `kill_cnt`.
- `kill_cnt`  in  KILL_W  number of subsequent accepted entries to discard.
- `kill_pending`  out  1  kill counter is nonzero.
- `occupancy`  out  2  number of valid entries held (0–2; maximum 1 when `SKID`=0).

## Operation
- Input transfer (IT) occurs when `in_valid`&&`in_ready`; output transfer (OT) occurs when `out_valid`&&`out_ready`.
- Storage consists of a main register (`main_v`, `main_d`) and, when `SKID`=1, a skid register (`skid_v`, `skid_d`).
- `out_valid`=`main_v`. `out_data`=`main_d` if `main_v`, else `BUBBLE`.
- `in_ready`:
  - `SKID`=1: `!skid_v`, taken directly from a flop.
  - `SKID`=0: `!main_v || out_ready`.
- Kill decision: an IT is killed when the counter value at the start of that cycle is nonzero. A killed IT completes the handshake but is dropped, and the counter decrements by 1.
- A new `kill_req` never kills the IT in its own cycle.
- Kill counter update, in priority order:
  1. `flush`: counter ← 0.
  2. `kill_req`: counter ← `kill_cnt` (overwrites any remaining count).
  3. Killed IT: counter ← counter−1.
- A `kill_cnt` of 0 is legal and leaves `kill_pending` at 0.
- Data movement for kept ITs, `SKID`=1:
  - main empty: IT → main.
  - main full with OT: skid → main if `skid_v`, else IT → main.
  - main full, no OT: IT → skid.
  - main full, OT, and `skid_v`: `in_ready`=0, so no IT occurs.
- Data movement, `SKID`=0: IT → main whenever main is empty or an OT occurs.
- Ordering: the skid entry is always older than any new input. Entries leave in FIFO order.
- `flush`: `main_v`, `skid_v` ← 0 and the counter ← 0. An IT in the flush cycle is accepted and dropped, and an OT in the flush cycle still completes. `main_d` ← `BUBBLE`.
- Reset values: `main_v`=0, `skid_v`=0, `main_d`=`skid_d`=`BUBBLE`, counter=0. The outputs are then `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1, `kill_pending`=0, `occupancy`=0.
- The asserted reset value of `in_ready` is 1 during reset; no IT is acted on while `rst`=1.
- Reset mid-operation discards all entries and any pending kill immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: an IT at edge k gives `out_valid`=1 with that payload after edge k, provided the stage was empty.
- Throughput is 1 entry per cycle while `out_ready`=1.
- When `SKID`=1, `in_ready` deasserts one cycle after the first stalled cycle with main full. The stage therefore absorbs exactly one extra entry, and `in_ready` has no combinational path from `out_ready`.
- `kill_pending` and `occupancy` are registered and reflect state after the most recent edge.
- `occupancy` increments or decrements by at most 1 per cycle; flush sets it to 0.
- Payload is held stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Reset/bubble:** `WIDTH`=16, `BUBBLE`=16'h0013. Assert `rst` asynchronously mid-cycle with 2 entries held → immediately `out_valid`=0, `out_data`=16'h0013, `occupancy`=0, `in_ready`=1.
- **Stream and skid:** Stream A,B,C at 1 entry/cycle, holding `out_ready`=0 from the cycle B arrives → A held on output, B in skid, `in_ready`=0, `occupancy`=2, C waits. Release `out_ready` → output order A,B,C with no loss or duplication.
- **Kill counter:** Pulse `kill_req` with `kill_cnt`=2 while entry X transfers in the same cycle. Then send Y,Z,W → X kept, Y and Z dropped, W output. `kill_pending` is 1 for exactly the 2 accepted cycles.
- **Kill reload:** While the counter=1, pulse `kill_req` with `kill_cnt`=3 and an IT in the same cycle → that IT is dropped, the counter becomes 3, and the next 3 ITs are dropped.
- **Flush priority:** Assert `flush`, `kill_req` (`kill_cnt`=2) and an IT in one cycle with 2 entries held → after the edge `occupancy`=0, `kill_pending`=0. The IT is dropped and the next IT is output normally.
- **`SKID`=0 mode:** `out_ready` toggling 1,0,1 while `in_valid`=1 → `in_ready` follows `out_ready` combinationally when main is full, and `occupancy` never exceeds 1.
